// File: rtl/pipe_ctrl_if.sv
// Debug-request, hazard and pipeline-control signals shared between the
// pipeline controller (slave) and the core/debug logic that drives it (master).
interface pipe_ctrl_if;
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic        clear_fault;
  logic        id_loadUseHazard;
  logic        ex_shouldJumpOrBranch;
  logic        wb_haltInstr;
  logic        mem_busy;
  logic        cpu_en;
  logic        id_shouldStall;
  logic        ex_bubble;
  logic        if_flush;
  logic        id_flush;
  logic [1:0]  state;
  logic        fault;
  logic [31:0] cycle_count;

  modport slave (
    input  run_req, halt_req, step_req, clear_fault,
           id_loadUseHazard, ex_shouldJumpOrBranch, wb_haltInstr, mem_busy,
    output cpu_en, id_shouldStall, ex_bubble, if_flush, id_flush,
           state, fault, cycle_count
  );

  modport master (
    output run_req, halt_req, step_req, clear_fault,
           id_loadUseHazard, ex_shouldJumpOrBranch, wb_haltInstr, mem_busy,
    input  cpu_en, id_shouldStall, ex_bubble, if_flush, id_flush,
           state, fault, cycle_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline run/halt/step controller: gates the global enable, qualifies hazard
// stall/flush strobes, and faults when memory stays busy too long.
module pipe_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {
    HALTED = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    FAULT  = 2'b11
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] cycle_count_q;
  logic        active, cpu_en, timeout;

  assign active  = (state_q == RUN) || (state_q == STEP);
  assign cpu_en  = active && !bus.mem_busy;
  // Last tolerated busy cycle: the edge closing it lands in FAULT.
  assign timeout = active && bus.mem_busy && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      HALTED: begin
        if (bus.halt_req)      state_d = HALTED;
        else if (bus.step_req) state_d = STEP;
        else if (bus.run_req)  state_d = RUN;
      end
      RUN: begin
        if (timeout)                                        state_d = FAULT;
        else if (bus.halt_req || (bus.wb_haltInstr && cpu_en)) state_d = HALTED;
      end
      STEP: begin
        if (timeout)                      state_d = FAULT;
        else if (bus.halt_req || cpu_en)  state_d = HALTED;
      end
      FAULT: begin
        if (bus.clear_fault) state_d = HALTED;
      end
      default: state_d = HALTED;
    endcase

    wait_cnt_d = 8'd0;
    if ((state_d == state_q) && active && bus.mem_busy)
      wait_cnt_d = wait_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= HALTED;
      wait_cnt_q    <= 8'd0;
      cycle_count_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (cpu_en) cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign bus.cpu_en         = cpu_en;
  assign bus.id_shouldStall = bus.id_loadUseHazard && cpu_en;
  assign bus.ex_bubble      = bus.id_loadUseHazard && cpu_en;
  assign bus.if_flush       = bus.ex_shouldJumpOrBranch && cpu_en;
  assign bus.id_flush       = bus.ex_shouldJumpOrBranch && cpu_en;
  assign bus.state          = state_q;
  assign bus.fault          = (state_q == FAULT);
  assign bus.cycle_count    = cycle_count_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a mode-level reference model checked every
// cycle, plus literal expectations at the interesting points.
module tb_pipe_ctrl;
  localparam int WT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmp_en = 1'b0;
  logic do_preset = 1'b0;
  int   total = 0;
  int   bad = 0;

  pipe_ctrl_if bus();

  pipe_ctrl #(.WAIT_TIMEOUT(WT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: mode 0 halted, 1 run, 2 step, 3 fault; m_busy counts the
  // consecutive busy cycles spent in the current run/step visit.
  int          m_mode;
  int          m_busy;
  logic [31:0] m_cnt;
  logic        m_active, m_en;

  assign m_active = (m_mode == 1) || (m_mode == 2);
  assign m_en     = m_active && !bus.mem_busy;

  function automatic int next_mode();
    if (m_active && bus.mem_busy && (m_busy + 1 >= WT)) return 3;
    case (m_mode)
      0:       return bus.halt_req ? 0 : bus.step_req ? 2 : bus.run_req ? 1 : 0;
      1:       return (bus.halt_req || (bus.wb_haltInstr && m_en)) ? 0 : 1;
      2:       return (bus.halt_req || m_en) ? 0 : 2;
      default: return bus.clear_fault ? 0 : 3;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 0;
      m_busy <= 0;
      m_cnt  <= 32'd0;
    end else begin
      m_mode <= next_mode();
      m_busy <= (next_mode() != m_mode || !m_active || !bus.mem_busy) ? 0 : m_busy + 1;
      m_cnt  <= do_preset ? 32'hFFFF_FFFE : m_cnt + (m_en ? 32'd1 : 32'd0);
    end
  end

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("state", 32'(bus.state), 32'(m_mode));
      chk("ctrl",
          32'({bus.cpu_en, bus.id_shouldStall, bus.ex_bubble, bus.if_flush, bus.id_flush, bus.fault}),
          32'({m_en, m_en && bus.id_loadUseHazard, m_en && bus.id_loadUseHazard,
               m_en && bus.ex_shouldJumpOrBranch, m_en && bus.ex_shouldJumpOrBranch, m_mode == 3}));
      chk("cycle_count", bus.cycle_count, m_cnt);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
    chk({tag, "_ctrl"}, 32'({bus.cpu_en, bus.id_shouldStall, bus.ex_bubble,
                             bus.if_flush, bus.id_flush, bus.fault}), 32'd0);
    chk({tag, "_count"}, bus.cycle_count, 32'd0);
  endtask

  initial begin
    bus.run_req = 0; bus.halt_req = 0; bus.step_req = 0; bus.clear_fault = 0;
    bus.id_loadUseHazard = 0; bus.ex_shouldJumpOrBranch = 0;
    bus.wb_haltInstr = 0; bus.mem_busy = 0;

    tick(2);
    chk_reset_outputs("reset");
    rst = 1; cmp_en = 1;

    // Release, then a run_req pulse enters RUN and counts 5 enabled edges
    tick(1);
    bus.run_req = 1; tick(1); bus.run_req = 0;
    chk("run_state", 32'(bus.state), 32'd1);
    chk("run_en", 32'(bus.cpu_en), 32'd1);
    tick(5);
    chk("run_count5", bus.cycle_count, 32'd5);

    // Load-use and taken branch together: all four strobes for one cycle
    bus.id_loadUseHazard = 1; bus.ex_shouldJumpOrBranch = 1; #1;
    chk("both_hz", 32'({bus.id_shouldStall, bus.ex_bubble, bus.if_flush, bus.id_flush}), 32'hF);
    tick(1);
    bus.id_loadUseHazard = 0; bus.ex_shouldJumpOrBranch = 0; #1;
    chk("both_hz_off", 32'({bus.id_shouldStall, bus.ex_bubble, bus.if_flush, bus.id_flush}), 32'h0);

    // Halt instruction retires in an enabled cycle, then HALTED
    bus.wb_haltInstr = 1; #1;
    chk("whalt_en", 32'(bus.cpu_en), 32'd1);
    tick(1); bus.wb_haltInstr = 0;
    chk("whalt_state", 32'(bus.state), 32'd0);
    chk("whalt_en_off", 32'(bus.cpu_en), 32'd0);
    chk("whalt_count", bus.cycle_count, 32'd7);

    // Step while memory busy for 3 cycles, then one enabled cycle
    bus.step_req = 1; bus.mem_busy = 1; tick(1); bus.step_req = 0;
    chk("step_hold", 32'({bus.state, bus.cpu_en}), 32'({2'b10, 1'b0}));
    tick(2);
    chk("step_hold3", 32'({bus.state, bus.cpu_en}), 32'({2'b10, 1'b0}));
    bus.mem_busy = 0; #1;
    chk("step_go", 32'(bus.cpu_en), 32'd1);
    tick(1);
    chk("step_done", 32'(bus.state), 32'd0);
    chk("step_count", bus.cycle_count, 32'd8);

    // Priority in HALTED: halt beats step
    bus.halt_req = 1; bus.step_req = 1; tick(1);
    bus.halt_req = 0; bus.step_req = 0;
    chk("prio_halt", 32'(bus.state), 32'd0);

    // Busy timeout in RUN; requests ignored in FAULT; clear_fault exits
    bus.run_req = 1; tick(1); bus.run_req = 0; bus.mem_busy = 1;
    tick(3);
    chk("pre_fault", 32'(bus.state), 32'd1);
    tick(1);
    chk("fault_state", 32'(bus.state), 32'd3);
    chk("fault_flag", 32'({bus.fault, bus.cpu_en}), 32'b10);
    bus.halt_req = 1; bus.run_req = 1; bus.step_req = 1; tick(1);
    chk("fault_sticky", 32'(bus.state), 32'd3);
    bus.halt_req = 0; bus.run_req = 0; bus.step_req = 0;
    bus.clear_fault = 1; tick(1); bus.clear_fault = 0; bus.mem_busy = 0;
    chk("fault_clear", 32'(bus.state), 32'd0);
    chk("fault_count", bus.cycle_count, 32'd8);

    // halt_req in STEP drops straight back to HALTED
    bus.step_req = 1; bus.mem_busy = 1; tick(1);
    bus.step_req = 0; bus.halt_req = 1; tick(1);
    bus.halt_req = 0; bus.mem_busy = 0;
    chk("step_halt", 32'(bus.state), 32'd0);

    // step_req held: one STEP per HALTED visit
    bus.step_req = 1; tick(4); bus.step_req = 0;
    chk("step_level", bus.cycle_count, 32'd10);

    // Preset counter near wrap, then two enabled cycles wrap to zero
    cmp_en = 0;
    force dut.cycle_count_q = 32'hFFFF_FFFE;
    do_preset = 1; tick(1); do_preset = 0;
    release dut.cycle_count_q;
    #1 cmp_en = 1;
    chk("preset", bus.cycle_count, 32'hFFFF_FFFE);
    bus.run_req = 1; tick(1); bus.run_req = 0;
    tick(1);
    chk("wrap_ff", bus.cycle_count, 32'hFFFF_FFFF);
    tick(1);
    chk("wrap_0", bus.cycle_count, 32'd0);

    // Asynchronous reset mid-cycle while running
    #2 rst = 0; #1;
    chk_reset_outputs("async_run");
    tick(1); rst = 1;

    // Asynchronous reset during FAULT leaves nothing pending
    bus.run_req = 1; tick(1); bus.run_req = 0; bus.mem_busy = 1;
    tick(4);
    chk("fault2", 32'(bus.state), 32'd3);
    #2 rst = 0; #1;
    chk_reset_outputs("async_fault");
    tick(1); bus.mem_busy = 0; rst = 1;
    tick(2);
    chk("post_rst", 32'(bus.state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: WAIT_TIMEOUT, default 255, number of consecutive mem_busy enabled cycles that triggers FAULT (range 1..255).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 run_req  input  1  debug request: leave HALTED and run freely.
REQ-006 halt_req  input  1  debug request: stop at the next edge.
REQ-007 step_req  input  1  debug request: execute exactly one enabled cycle.
REQ-008 clear_fault  input  1  leave FAULT, go to HALTED.
REQ-009 id_loadUseHazard  input  1  ID stage needs a one-cycle stall.
REQ-010 ex_shouldJumpOrBranch  input  1  EX resolves a taken jump or branch.
REQ-011 wb_haltInstr  input  1  halt instruction retiring in WB.
REQ-012 mem_busy  input  1  data/instruction memory not ready; freeze pipeline.
REQ-013 cpu_en  output  1  global pipeline enable, also drives the PC register enable.
REQ-014 id_shouldStall  output  1  hold PC and IF/ID.
REQ-015 ex_bubble  output  1  insert NOP into ID/EX.
REQ-016 if_flush  output  1  squash IF/ID.
REQ-017 id_flush  output  1  squash ID/EX.
REQ-018 state  output  2  00 HALTED, 01 RUN, 10 STEP, 11 FAULT.
REQ-019 fault  output  1  high while state == FAULT.
REQ-020 cycle_count  output  32  count of cycles with cpu_en = 1, wraps.

Function
REQ-021 cpu_en SHALL equal (state==RUN or state==STEP) and not mem_busy, combinationally.
REQ-022 id_shouldStall and ex_bubble SHALL each equal id_loadUseHazard and cpu_en.
REQ-023 if_flush and id_flush SHALL each equal ex_shouldJumpOrBranch and cpu_en.
REQ-024 On simultaneous load-use and branch, all four of id_shouldStall, ex_bubble, if_flush and id_flush SHALL assert; the PC takes the branch target.
REQ-025 HALTED transitions: halt_req stays in HALTED; else step_req goes to STEP; else run_req goes to RUN. Priority is halt > step > run.
REQ-026 RUN: halt_req goes to HALTED at the next edge.
REQ-027 RUN: wb_haltInstr with cpu_en=1 goes to HALTED at the next edge; that cycle is still enabled.
REQ-028 STEP: stays in STEP until a cycle with cpu_en=1, then goes to HALTED at that edge. halt_req in STEP goes to HALTED immediately.
REQ-029 wait_cnt (8-bit) SHALL increment each RUN/STEP cycle with mem_busy=1 and clear on any cycle with mem_busy=0 or a state change.
REQ-030 When mem_busy=1 and wait_cnt == WAIT_TIMEOUT-1, the next state SHALL be FAULT.
- FAULT has priority over halt_req and wb_haltInstr.
REQ-031 FAULT: cpu_en=0, all hazard outputs 0, fault=1.
- clear_fault goes to HALTED; all other requests are ignored.
REQ-032 cycle_count SHALL increment by 1 on each edge where cpu_en=1, wrapping 0xFFFFFFFF to 0.
REQ-033 Request inputs SHALL be level-sampled; a request held high repeats its effect, e.g. step_req held high gives one STEP per HALTED visit.

Reset
REQ-034 While rst=0, the block SHALL immediately set state=HALTED, wait_cnt=0 and cycle_count=0; hence cpu_en=0, all hazard outputs 0 and fault=0.
REQ-035 Reset asserted mid-operation, including in FAULT or during a mem_busy wait, SHALL abort at once with no pending effect after release.
REQ-036 The first edge after rst rises SHALL evaluate REQ-025 normally.

Verification
REQ-037 Reset release, run_req pulse at cycle 2 -> state=01 from cycle 3; cpu_en=1; cycle_count=5 after 5 further edges.
REQ-038 RUN, step-free; id_loadUseHazard=1 for 1 cycle with ex_shouldJumpOrBranch=1 same cycle -> id_shouldStall, ex_bubble, if_flush and id_flush all 1 that cycle only.
REQ-039 HALTED, step_req=1 for one cycle while mem_busy=1 for 3 cycles -> STEP held with cpu_en=0 for 3 cycles, then 1 enabled cycle, then HALTED; cycle_count +1.
REQ-040 RUN, WAIT_TIMEOUT=4, mem_busy held high -> FAULT after the 4th busy cycle; fault=1; clear_fault -> HALTED next edge.
REQ-041 RUN, wb_haltInstr=1 with halt_req=0 -> that cycle is enabled, then state=00 with cpu_en=0.
REQ-042 cycle_count preset to 0xFFFFFFFE by running; 2 enabled cycles -> 0x00000000. Assert rst=0 mid-cycle -> outputs are reset values before the next clk edge.
